// File: rtl/adc_fifo_to_frame.sv
// rtl/adc_fifo_to_frame.sv - ADC stream FIFO pop-side frame reassembler (optional ADC_RX_SEQ_CHECK_EN)
module adc_fifo_to_frame #(
    parameter int         WORDS          = 9,
    parameter logic [7:0] SYNC_TAG       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pop_valid,
    input  logic [31:0]           pop_data,
    output logic                  pop_ready,
    output logic                  frame_valid,
    output logic [32*WORDS-1:0]   frame_words_packed,
    input  logic                  frame_ready,
    output logic                  frame_abort,
    output logic                  seq_gap,
    output logic [15:0]           drop_count
);

    localparam int IDX_W  = $clog2(WORDS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [32*WORDS-1:0] frame_q, frame_d;
    logic                pop_ready_q, pop_ready_d;
    logic                frame_valid_q, frame_valid_d;
    logic                abort_q, abort_d;
    logic [15:0]         drop_q, drop_d;
    logic                accept;
    logic                drop_inc;
    logic                done;

    assign accept = pop_valid && pop_ready_q;

    // Next-state: header hunt, in-place word collection, idle timeout and consumer hold
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        idle_d   = idle_q;
        frame_d  = frame_q;
        abort_d  = 1'b0;
        drop_inc = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (accept) begin
                    if (pop_data[31:24] == SYNC_TAG) begin
                        frame_d[31:0] = pop_data;
                        idle_d        = '0;
                        if (WORDS == 1) begin
                            state_d = ST_HOLD;
                            idx_d   = '0;
                            done    = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            frame_d[k*32 +: 32] = pop_data;
                        end
                    end
                    idle_d = '0;
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        state_d = ST_HOLD;
                        idx_d   = '0;
                        done    = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    // Producer stalled mid-frame: throw the partial frame away
                    state_d  = ST_HUNT;
                    abort_d  = 1'b1;
                    drop_inc = 1'b1;
                    idx_d    = '0;
                    idle_d   = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
        pop_ready_d   = (state_d != ST_HOLD);
        frame_valid_d = (state_d == ST_HOLD);
        drop_d        = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            idx_q         <= '0;
            idle_q        <= '0;
            frame_q       <= '0;
            pop_ready_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            abort_q       <= 1'b0;
            drop_q        <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            idle_q        <= idle_d;
            frame_q       <= frame_d;
            pop_ready_q   <= pop_ready_d;
            frame_valid_q <= frame_valid_d;
            abort_q       <= abort_d;
            drop_q        <= drop_d;
        end
    end

    assign pop_ready          = pop_ready_q;
    assign frame_valid        = frame_valid_q;
    assign frame_words_packed = frame_q;
    assign frame_abort        = abort_q;
    assign drop_count         = drop_q;

`ifdef ADC_RX_SEQ_CHECK_EN
    logic [7:0] exp_seq_q, exp_seq_d;
    logic       have_seq_q, have_seq_d;
    logic       gap_q, gap_d;

    // Compare the header sequence of each completed frame against the running expectation
    always_comb begin
        exp_seq_d  = exp_seq_q;
        have_seq_d = have_seq_q;
        gap_d      = 1'b0;
        if (done) begin
            gap_d      = have_seq_q && (frame_d[23:16] != exp_seq_q);
            exp_seq_d  = frame_d[23:16] + 8'd1;
            have_seq_d = 1'b1;
        end
    end

    // Sequence tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_seq_q  <= 8'd0;
            have_seq_q <= 1'b0;
            gap_q      <= 1'b0;
        end else begin
            exp_seq_q  <= exp_seq_d;
            have_seq_q <= have_seq_d;
            gap_q      <= gap_d;
        end
    end

    assign seq_gap = gap_q;
`else
    assign seq_gap = 1'b0;
`endif

endmodule

// File: tb/tb_adc_fifo_to_frame.sv
// tb/tb_adc_fifo_to_frame.sv - directed table-driven bench for adc_fifo_to_frame
module tb_adc_fifo_to_frame;

    localparam int WORDS = 9;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                pop_valid;
    logic [31:0]         pop_data;
    logic                pop_ready;
    logic                frame_valid;
    logic [32*WORDS-1:0] frame_words_packed;
    logic                frame_ready;
    logic                frame_abort;
    logic                seq_gap;
    logic [15:0]         drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int abort_seen = 0;

    typedef struct {
        int          junk;
        logic [7:0]  seq;
        logic [31:0] base;
        int          hold;
        logic [15:0] exp_drop;
        logic        exp_gap;
    } vec_t;

    vec_t vecs[5];

    adc_fifo_to_frame #(.WORDS(WORDS), .SYNC_TAG(8'hA5), .TIMEOUT_CYCLES(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pop_valid          (pop_valid),
        .pop_data           (pop_data),
        .pop_ready          (pop_ready),
        .frame_valid        (frame_valid),
        .frame_words_packed (frame_words_packed),
        .frame_ready        (frame_ready),
        .frame_abort        (frame_abort),
        .seq_gap            (seq_gap),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_abort === 1'b1) abort_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop(input logic [31:0] data);
        for (int n = 0; n < 100 && pop_ready !== 1'b1; n++) @(negedge clk);
        if (pop_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_ready_timeout: got %b expected 1", pop_ready);
        end
        pop_valid = 1'b1;
        pop_data  = data;
        @(posedge clk);
        @(negedge clk);
        pop_valid = 1'b0;
    endtask

    task automatic do_frame(input vec_t v);
        logic [31:0] exp_w;
        logic        gap_exp;
`ifdef ADC_RX_SEQ_CHECK_EN
        gap_exp = v.exp_gap;
`else
        gap_exp = 1'b0;
`endif
        for (int j = 0; j < v.junk; j++) pop(32'h12345678);
        pop({8'hA5, v.seq, 16'h0000});
        for (int k = 1; k < WORDS; k++) pop(v.base + k);
        check("frame_valid_after_last", {31'd0, frame_valid}, 32'd1);
        check("pop_ready_in_hold", {31'd0, pop_ready}, 32'd0);
        check("seq_gap_first_valid", {31'd0, seq_gap}, {31'd0, gap_exp});
        check("drop_count", {16'd0, drop_count}, {16'd0, v.exp_drop});
        for (int k = 0; k < WORDS; k++) begin
            exp_w = (k == 0) ? {8'hA5, v.seq, 16'h0000} : v.base + k;
            check($sformatf("word%0d", k), frame_words_packed[k*32 +: 32], exp_w);
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, frame_valid}, 32'd1);
            check("hold_pop_ready", {31'd0, pop_ready}, 32'd0);
            check("hold_seq_gap", {31'd0, seq_gap}, 32'd0);
            check("hold_word0_stable", frame_words_packed[31:0], {8'hA5, v.seq, 16'h0000});
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check("release_valid", {31'd0, frame_valid}, 32'd0);
        check("release_pop_ready", {31'd0, pop_ready}, 32'd1);
        check("release_seq_gap", {31'd0, seq_gap}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{junk: 0, seq: 8'd0, base: 32'h0,        hold: 2, exp_drop: 16'd0, exp_gap: 1'b0};
        vecs[1] = '{junk: 3, seq: 8'd1, base: 32'h100,      hold: 0, exp_drop: 16'd3, exp_gap: 1'b0};
        vecs[2] = '{junk: 0, seq: 8'd3, base: 32'h200,      hold: 1, exp_drop: 16'd3, exp_gap: 1'b1};
        vecs[3] = '{junk: 1, seq: 8'd4, base: 32'hA5FF0000, hold: 0, exp_drop: 16'd4, exp_gap: 1'b0};
        vecs[4] = '{junk: 0, seq: 8'd5, base: 32'h300,      hold: 1, exp_drop: 16'd5, exp_gap: 1'b0};

        rst_n       = 1'b0;
        pop_valid   = 1'b1;
        pop_data    = 32'hA5000000;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pop_ready", {31'd0, pop_ready}, 32'd0);
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_frame_abort", {31'd0, frame_abort}, 32'd0);
        check("rst_seq_gap", {31'd0, seq_gap}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_packed_zero", {31'd0, |frame_words_packed}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_pop_ready_low", {31'd0, pop_ready}, 32'd0);
        @(negedge clk);
        check("pop_ready_one_edge", {31'd0, pop_ready}, 32'd1);
        pop_valid = 1'b0;
        @(negedge clk);
        check("no_accept_before_ready", {31'd0, frame_valid}, 32'd0);

        for (int i = 0; i < 4; i++) do_frame(vecs[i]);
        check("no_abort_in_frames", abort_seen, 0);

        pop({8'hA5, 8'h07, 16'h0000});
        for (int k = 1; k <= 3; k++) pop(32'hDEAD0000 + k);
        for (int j = 1; j <= 63; j++) @(negedge clk);
        check("abort_not_early", abort_seen, 0);
        @(negedge clk);
        check("abort_pulse", {31'd0, frame_abort}, 32'd1);
        check("abort_drop_count", {16'd0, drop_count}, 32'd5);
        @(negedge clk);
        check("abort_one_cycle", {31'd0, frame_abort}, 32'd0);
        check("abort_pop_ready", {31'd0, pop_ready}, 32'd1);
        check("abort_no_valid", {31'd0, frame_valid}, 32'd0);
        do_frame(vecs[4]);
        check("abort_count_total", abort_seen, 1);

        pop({8'hA5, 8'h09, 16'h0000});
        for (int k = 1; k <= 3; k++) pop(32'hBEEF0000 + k);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pop_ready", {31'd0, pop_ready}, 32'd0);
        check("async_drop_count", {16'd0, drop_count}, 32'd0);
        check("async_packed_zero", {31'd0, |frame_words_packed}, 32'd0);
        check("async_abort", {31'd0, frame_abort}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        check("async_no_valid", {31'd0, frame_valid}, 32'd0);
        check("async_no_abort", abort_seen, 1);
        check("async_pop_ready_back", {31'd0, pop_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
